// File: rtl/hfu_pkg.sv
// hfu_pkg: scoreboard entry type and forward-select sizing shared by hazard_forward_unit
package hfu_pkg;
    // rd is held zero-extended so the entry layout does not depend on REG_AW
    localparam int RD_MAX   = 8;
    localparam int FWD_NONE = 0;
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [RD_MAX-1:0] rd;
        logic              is_load;
        logic              store_fwd;
    } sb_entry_t;
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/hfu_src_match.sv
// hfu_src_match: youngest-first forward select for one EX source across stages EX+1..EX+DEPTH
module hfu_src_match import hfu_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int SW    = 2
) (
    input  logic [DEPTH-1:0]             wr_v,
    input  logic [DEPTH-1:0][RD_MAX-1:0] wr_rd,
    input  logic [RD_MAX-1:0]            rs,
    input  logic                         use_rs,
    output logic [SW-1:0]                sel
);
    always_comb begin
        sel = SW'(FWD_NONE);
        for (int j = DEPTH - 1; j >= 0; j--)
            if (wr_v[j] && use_rs && rs != '0 && wr_rd[j] == rs) sel = SW'(j + 1);
    end
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: scoreboard-based EX forwarding and load-use stall; HFU_STORE_FWD_EN adds MEM store-data forwarding
module hazard_forward_unit import hfu_pkg::*; #(
    parameter int NUM_SRC   = 2,
    parameter int DEPTH     = 2,
    parameter int REG_AW    = 5,
    parameter int STORE_SRC = 1,
    parameter int CNT_W     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 advance,
    input  logic                                 flush,
    input  logic                                 id_valid,
    input  logic [REG_AW-1:0]                    id_rd,
    input  logic                                 id_regwrite,
    input  logic                                 id_is_load,
    input  logic                                 id_is_store,
    input  logic [NUM_SRC-1:0][REG_AW-1:0]       id_rs,
    input  logic [NUM_SRC-1:0]                   id_uses_rs,
    output logic                                 stall,
    output logic [NUM_SRC-1:0][sel_w(DEPTH)-1:0] fwd_sel,
    output logic                                 mem_fwd,
    output logic [CNT_W-1:0]                     stall_cnt
);
    localparam int SW = sel_w(DEPTH);
    sb_entry_t [DEPTH:0]            e_q, e_d;
    logic [NUM_SRC-1:0][REG_AW-1:0] ex_rs_q, ex_rs_d;
    logic [NUM_SRC-1:0]             ex_uses_q, ex_uses_d, haz, exempt;
    logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;
    logic [DEPTH-1:0]               wr_v;
    logic [DEPTH-1:0][RD_MAX-1:0]   wr_rd;
    logic                           take, unused_sb;
    sb_entry_t                      ins;

`ifdef HFU_STORE_FWD_EN
    assign exempt  = id_is_store ? NUM_SRC'(1) << STORE_SRC : '0;
    assign mem_fwd = e_q[1].valid & e_q[1].store_fwd;
`else
    logic unused_store;
    assign exempt       = '0;
    assign mem_fwd      = 1'b0;
    assign unused_store = id_is_store;
`endif

    assign unused_sb = e_q[DEPTH].is_load ^ e_q[DEPTH].store_fwd;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        haz = '0;
        for (int i = 0; i < NUM_SRC; i++)
            haz[i] = id_valid && id_uses_rs[i] && id_rs[i] != '0 && e_q[0].valid && e_q[0].regwrite
                     && e_q[0].is_load && e_q[0].rd == RD_MAX'(id_rs[i]);
    end

    // flush beats a stall for EX insertion, but the stall is still reported and counted
    always_comb begin
        stall       = |(haz & ~exempt);
        take        = id_valid && !stall && !flush;
        ins         = take ? sb_entry_t'{valid: 1'b1, regwrite: id_regwrite, rd: RD_MAX'(id_rd),
                                         is_load: id_is_load, store_fwd: |(haz & exempt)} : '0;
        e_d         = advance ? {e_q[DEPTH-1:0], ins} : e_q;
        ex_rs_d     = advance ? (take ? id_rs : '0) : ex_rs_q;
        ex_uses_d   = advance ? (take ? id_uses_rs : '0) : ex_uses_q;
        stall_cnt_d = stall_cnt_q + CNT_W'(advance && stall && !(&stall_cnt_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q         <= '0;
            ex_rs_q     <= '0;
            ex_uses_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            ex_rs_q     <= ex_rs_d;
            ex_uses_q   <= ex_uses_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        wr_v  = '0;
        wr_rd = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            wr_v[k-1]  = e_q[k].valid && e_q[k].regwrite;
            wr_rd[k-1] = e_q[k].rd;
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hfu_src_match #(.DEPTH(DEPTH), .SW(SW)) u_match (
            .wr_v   (wr_v),
            .wr_rd  (wr_rd),
            .rs     (RD_MAX'(ex_rs_q[s])),
            .use_rs (ex_uses_q[s]),
            .sel    (fwd_sel[s])
        );
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed checks of forwarding, load-use stall, freeze, flush, reset and counter saturation
module tb_hazard_forward_unit;
    logic            clk = 1'b0, rst_n = 1'b0, advance = 1'b0, flush = 1'b0;
    logic            id_valid = 1'b0, id_regwrite = 1'b0, id_is_load = 1'b0, id_is_store = 1'b0;
    logic [4:0]      id_rd = '0;
    logic [1:0][4:0] id_rs = '0;
    logic [1:0]      id_uses_rs = '0;
    logic            stall, mem_fwd;
    logic [1:0][1:0] fwd_sel;
    logic [15:0]     stall_cnt;
    int              checks = 0, failures = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (advance),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .id_is_store (id_is_store),
        .id_rs       (id_rs),
        .id_uses_rs  (id_uses_rs),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .mem_fwd     (mem_fwd),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic v, rw, ld, st, input logic [4:0] rd, rs0, rs1, input logic [1:0] uses);
        id_valid    = v;
        id_regwrite = rw;
        id_is_load  = ld;
        id_is_store = st;
        id_rd       = rd;
        id_rs[0]    = rs0;
        id_rs[1]    = rs1;
        id_uses_rs  = uses;
        #1;
    endtask

    task automatic drain();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        repeat (3) tick();
    endtask

    initial begin
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_fwd", fwd_sel, 0);
        chk("rst_mem_fwd", mem_fwd, 0);
        chk("rst_cnt", stall_cnt, 0);
        #10 rst_n = 1'b1;
        advance = 1'b1;
        tick();

        // back-to-back ALU producer/consumer, then two apart with rs1 unused
        id(1, 1, 0, 0, 5, 1, 2, 2'b11); tick();
        id(1, 1, 0, 0, 6, 5, 0, 2'b11);
        chk("alu_b2b_stall", stall, 0);
        tick();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("alu_b2b_fwd0", fwd_sel[0], 1);
        chk("alu_b2b_fwd1", fwd_sel[1], 0);
        id(1, 1, 0, 0, 8, 1, 2, 2'b11); tick();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00); tick();
        id(1, 1, 0, 0, 9, 8, 8, 2'b01); tick();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("alu_gap2_fwd0", fwd_sel[0], 2);
        chk("alu_unused_fwd1", fwd_sel[1], 0);

        // two producers of x5: MEM copy wins; x0 never forwards
        id(1, 1, 0, 0, 5, 1, 2, 2'b11); tick();
        id(1, 1, 0, 0, 5, 3, 4, 2'b11); tick();
        id(1, 1, 0, 0, 9, 5, 0, 2'b11); tick();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("dbl_youngest", fwd_sel[0], 1);
        id(1, 1, 0, 0, 0, 1, 2, 2'b11); tick();
        id(1, 1, 0, 0, 9, 0, 0, 2'b11); tick();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("x0_fwd0", fwd_sel[0], 0);
        chk("x0_fwd1", fwd_sel[1], 0);

        // load-use: one bubble, then forward from WB
        drain();
        id(1, 1, 1, 0, 7, 1, 0, 2'b01); tick();
        id(1, 1, 0, 0, 9, 7, 2, 2'b11);
        chk("lu_stall", stall, 1);
        chk("lu_cnt_before", stall_cnt, 0);
        tick();
        exp_cnt = 1;
        chk("lu_cnt_after", stall_cnt, exp_cnt);
        chk("lu_stall_released", stall, 0);
        tick();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("lu_fwd0", fwd_sel[0], 2);
        chk("lu_fwd1", fwd_sel[1], 0);

        // load followed by store using the loaded value as store data
        drain();
        id(1, 1, 1, 0, 7, 1, 0, 2'b01); tick();
        id(1, 0, 0, 1, 0, 3, 7, 2'b11);
`ifdef HFU_STORE_FWD_EN
        chk("st_stall", stall, 0);
        tick();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("st_fwd1", fwd_sel[1], 1);
        tick();
        chk("st_mem_fwd", mem_fwd, 1);
`else
        chk("st_stall", stall, 1);
        tick();
        exp_cnt++;
        chk("st_stall_released", stall, 0);
        tick();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("st_fwd1", fwd_sel[1], 2);
        tick();
        chk("st_mem_fwd", mem_fwd, 0);
`endif
        chk("st_cnt", stall_cnt, exp_cnt);

        // freeze during a load-use stall
        drain();
        id(1, 1, 1, 0, 7, 1, 0, 2'b01); tick();
        id(1, 1, 0, 0, 9, 7, 0, 2'b01);
        chk("frz_stall", stall, 1);
        advance = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("frz_stall_held", stall, 1);
            chk("frz_cnt_held", stall_cnt, exp_cnt);
        end
        advance = 1'b1;
        tick();
        exp_cnt++;
        chk("frz_cnt_resume", stall_cnt, exp_cnt);
        chk("frz_stall_released", stall, 0);
        tick();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("frz_fwd0", fwd_sel[0], 2);

        // flushed instruction becomes a bubble that nothing forwards from
        drain();
        id(1, 1, 0, 0, 10, 1, 2, 2'b11); tick();
        flush = 1'b1;
        id(1, 1, 0, 0, 12, 10, 0, 2'b01); tick();
        flush = 1'b0;
        id(1, 1, 0, 0, 13, 12, 0, 2'b01); tick();
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("flush_bubble_fwd0", fwd_sel[0], 0);

        // flush together with stall: still counted
        drain();
        id(1, 1, 1, 0, 7, 1, 0, 2'b01); tick();
        flush = 1'b1;
        id(1, 1, 0, 0, 9, 7, 0, 2'b01);
        chk("flush_stall", stall, 1);
        tick();
        flush = 1'b0;
        exp_cnt++;
        chk("flush_stall_cnt", stall_cnt, exp_cnt);

        // reset with three valid entries in flight
        drain();
        id(1, 1, 0, 0, 5, 1, 2, 2'b11); tick();
        id(1, 1, 0, 0, 6, 1, 2, 2'b11); tick();
        id(1, 1, 1, 0, 7, 6, 0, 2'b01); tick();
        id(1, 1, 0, 0, 9, 7, 5, 2'b11);
        chk("pre_rst_stall", stall, 1);
        chk("pre_rst_fwd0", fwd_sel[0], 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_fwd", fwd_sel, 0);
        chk("mid_rst_mem_fwd", mem_fwd, 0);
        chk("mid_rst_cnt", stall_cnt, 0);
        #1 rst_n = 1'b1;

        // counter saturation
        id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        advance = 1'b0;
        force dut.stall_cnt_q = 16'hFFFE;
        #1 release dut.stall_cnt_q;
        advance = 1'b1;
        id(1, 1, 1, 0, 7, 1, 0, 2'b01); tick();
        id(1, 1, 0, 0, 9, 7, 0, 2'b01); tick();
        chk("sat_reach", stall_cnt, 16'hFFFF);
        tick();
        id(1, 1, 1, 0, 7, 1, 0, 2'b01); tick();
        id(1, 1, 0, 0, 9, 7, 0, 2'b01);
        chk("sat_stall", stall, 1);
        tick();
        chk("sat_hold", stall_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
